// File: rtl/cu_param_pkg.sv
// Shared opcode, state and ALU encodings for the parametrised control unit.
package cu_pkg;
    localparam int OP_MV   = 0;
    localparam int OP_MVI  = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_MVNZ = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
endpackage

// File: rtl/cu_param_if.sv
// Control-unit <-> datapath signal bundle; master is the datapath side.
interface cu_param_if #(
    parameter int NREGS = 8,
    parameter int OPW   = 3
);
    localparam int REGW = $clog2(NREGS);
    localparam int IR_W = OPW + 2*REGW;

    logic             Run;
    logic [IR_W-1:0]  IR;
    logic             Gz;
    logic             IRin;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic             Ain;
    logic             Gin;
    logic             Gout;
    logic             DINout;
    logic [1:0]       AluOp;
    logic             Done;
    logic             Illegal;

    modport master (
        output Run, IR, Gz,
        input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done, Illegal
    );
    modport slave (
        input  Run, IR, Gz,
        output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done, Illegal
    );
endinterface

// File: rtl/cu_param_onehot_dec.sv
// Binary index to one-hot; a low enable forces every output bit to 0.
module cu_onehot_dec #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] i_idx,
    input  logic         i_en,
    output logic [N-1:0] o_oh
);
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_oh[i] = i_en && (i_idx == W'(i));
    end
endmodule

// File: rtl/cu_param.sv
// Multi-cycle control unit: IDLE/T0 fetch, T1 decode, T2/T3 ALU sequence.
module cu_param
    import cu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int OPW   = 3
) (
    input logic       clk,
    input logic       Resetn,
    cu_param_if.slave bus
);
    localparam int REGW = $clog2(NREGS);
    localparam int IR_W = OPW + 2*REGW;

    state_t r_state, w_next;

    logic [OPW-1:0]   w_op;
    logic [REGW-1:0]  w_x, w_y;
    logic [NREGS-1:0] w_xoh, w_yoh;
    logic [1:0]       w_aluop;
    logic w_is_alu, w_legal;
    logic w_irin, w_rin_x, w_rout_x, w_rout_y, w_ain, w_gin, w_gout, w_dinout;
    logic w_alu_en, w_done, w_illegal;

    assign w_op     = bus.IR[IR_W-1 -: OPW];
    assign w_x      = bus.IR[2*REGW-1 -: REGW];
    assign w_y      = bus.IR[REGW-1:0];
    assign w_is_alu = (w_op >= OPW'(OP_ADD)) && (w_op <= OPW'(OP_OR));
    assign w_legal  = (w_op <= OPW'(OP_MVNZ));
    // op - 2 modulo 4 only needs the low two opcode bits
    assign w_aluop  = w_op[1:0] - 2'd2;

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.Run) w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = (w_legal && w_is_alu) ? S_T2 : S_IDLE;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_irin    = 1'b0;
        w_rin_x   = 1'b0;
        w_rout_x  = 1'b0;
        w_rout_y  = 1'b0;
        w_ain     = 1'b0;
        w_gin     = 1'b0;
        w_gout    = 1'b0;
        w_dinout  = 1'b0;
        w_alu_en  = 1'b0;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_T0: w_irin = 1'b1;
            S_T1: begin
                if (!w_legal) begin
                    w_done    = 1'b1;
                    w_illegal = 1'b1;
                end else if (w_is_alu) begin
                    w_rout_x = 1'b1;
                    w_ain    = 1'b1;
                end else if (w_op == OPW'(OP_MVI)) begin
                    w_dinout = 1'b1;
                    w_rin_x  = 1'b1;
                    w_done   = 1'b1;
                end else begin
                    // mv, or mvnz: the copy is suppressed when G is zero
                    w_done = 1'b1;
                    if (w_op == OPW'(OP_MV) || !bus.Gz) begin
                        w_rout_y = 1'b1;
                        w_rin_x  = 1'b1;
                    end
                end
            end
            S_T2: begin
                w_rout_y = 1'b1;
                w_gin    = 1'b1;
                w_alu_en = 1'b1;
            end
            S_T3: begin
                w_gout   = 1'b1;
                w_rin_x  = 1'b1;
                w_done   = 1'b1;
                w_alu_en = 1'b1;
            end
            default: ;
        endcase
    end

    cu_onehot_dec #(.N(NREGS), .W(REGW)) u_dec_x (
        .i_idx (w_x),
        .i_en  (w_rin_x | w_rout_x),
        .o_oh  (w_xoh)
    );

    cu_onehot_dec #(.N(NREGS), .W(REGW)) u_dec_y (
        .i_idx (w_y),
        .i_en  (w_rout_y),
        .o_oh  (w_yoh)
    );

    assign bus.IRin    = w_irin;
    assign bus.Rin     = w_rin_x ? w_xoh : '0;
    assign bus.Rout    = (w_rout_x ? w_xoh : '0) | w_yoh;
    assign bus.Ain     = w_ain;
    assign bus.Gin     = w_gin;
    assign bus.Gout    = w_gout;
    assign bus.DINout  = w_dinout;
    assign bus.AluOp   = (w_alu_en && w_is_alu) ? w_aluop : ALU_ADD;
    assign bus.Done    = w_done;
    assign bus.Illegal = w_illegal;

    a_onehot: assert property (@(posedge clk) disable iff (!Resetn)
        $onehot0(bus.Rin) && $onehot0(bus.Rout));
    a_bus_excl: assert property (@(posedge clk) disable iff (!Resetn)
        $countones({bus.Rout, bus.DINout, bus.Gout}) <= 1);
    a_done_irin: assert property (@(posedge clk) disable iff (!Resetn)
        !(bus.Done && bus.IRin));
    a_done_pulse: assert property (@(posedge clk) disable iff (!Resetn)
        bus.Done |=> !bus.Done);
endmodule

// File: tb/tb_cu_param.sv
// Directed checks of cu_param at 8 regs/3-bit opcode and 16 regs/4-bit opcode.
module tb_cu_param;
    logic clk = 1'b0;
    logic Resetn;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    cu_param_if #(.NREGS(8),  .OPW(3)) b8();
    cu_param_if #(.NREGS(16), .OPW(4)) b16();

    cu_param #(.NREGS(8),  .OPW(3)) u8  (.clk(clk), .Resetn(Resetn), .bus(b8));
    cu_param #(.NREGS(16), .OPW(4)) u16 (.clk(clk), .Resetn(Resetn), .bus(b16));

    always @(negedge clk) if (b8.Done === 1'b1) n_done++;

    localparam logic [63:0] Z = '0;

    function automatic logic [63:0] pk(logic irin, logic [15:0] rin, logic [15:0] rout,
                                       logic ain, logic gin, logic gout, logic din,
                                       logic [1:0] alu, logic done, logic ill);
        return {23'b0, irin, rin, rout, ain, gin, gout, din, alu, done, ill};
    endfunction

    function automatic logic [63:0] o8();
        return pk(b8.IRin, {8'b0, b8.Rin}, {8'b0, b8.Rout}, b8.Ain, b8.Gin, b8.Gout,
                  b8.DINout, b8.AluOp, b8.Done, b8.Illegal);
    endfunction

    function automatic logic [63:0] o16();
        return pk(b16.IRin, b16.Rin, b16.Rout, b16.Ain, b16.Gin, b16.Gout,
                  b16.DINout, b16.AluOp, b16.Done, b16.Illegal);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        Resetn = 1'b0;
        b8.Run = 1'b0;  b8.IR = '0;  b8.Gz = 1'b0;
        b16.Run = 1'b0; b16.IR = '0; b16.Gz = 1'b0;
        tick(); tick();
        chk("reset8", o8(), Z);
        chk("reset16", o16(), Z);
        Resetn = 1'b1;
        tick();
        chk("idle", o8(), Z);

        // mv R3<-R5
        b8.IR = 9'b000_011_101; b8.Run = 1'b1;
        #1 chk("idle_run", o8(), Z);
        tick(); chk("mv_t0", o8(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b8.Run = 1'b0;
        tick(); chk("mv_t1", o8(), pk(0, 16'h08, 16'h20, 0, 0, 0, 0, 2'b00, 1, 0));
        tick(); chk("mv_after", o8(), Z);

        // sub R1,R2
        b8.IR = 9'b011_001_010; b8.Run = 1'b1;
        tick(); chk("sub_t0", o8(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b8.Run = 1'b0;
        tick(); chk("sub_t1", o8(), pk(0, 0, 16'h02, 1, 0, 0, 0, 2'b00, 0, 0));
        tick(); chk("sub_t2", o8(), pk(0, 0, 16'h04, 0, 1, 0, 0, 2'b01, 0, 0));
        tick(); chk("sub_t3", o8(), pk(0, 16'h02, 0, 0, 0, 1, 0, 2'b01, 1, 0));
        tick(); chk("sub_after", o8(), Z);

        // mvnz R0<-R7 with G zero, then with G nonzero
        b8.IR = 9'b110_000_111; b8.Gz = 1'b1; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("mvnz_gz1", o8(), pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        tick(); b8.Gz = 1'b0; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("mvnz_gz0", o8(), pk(0, 16'h01, 16'h80, 0, 0, 0, 0, 2'b00, 1, 0));
        tick();

        // mvi R6
        b8.IR = 9'b001_110_000; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("mvi_t1", o8(), pk(0, 16'h40, 0, 0, 0, 0, 1, 2'b00, 1, 0));
        tick();

        // and R4,R4: x == y
        b8.IR = 9'b100_100_100; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("and_t1", o8(), pk(0, 0, 16'h10, 1, 0, 0, 0, 2'b00, 0, 0));
        tick(); chk("and_t2", o8(), pk(0, 0, 16'h10, 0, 1, 0, 0, 2'b10, 0, 0));
        tick(); chk("and_t3", o8(), pk(0, 16'h10, 0, 0, 0, 1, 0, 2'b10, 1, 0));
        tick();

        // or R2,R3
        b8.IR = 9'b101_010_011; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("or_t1", o8(), pk(0, 0, 16'h04, 1, 0, 0, 0, 2'b00, 0, 0));
        tick(); chk("or_t2", o8(), pk(0, 0, 16'h08, 0, 1, 0, 0, 2'b11, 0, 0));
        tick(); chk("or_t3", o8(), pk(0, 16'h04, 0, 0, 0, 1, 0, 2'b11, 1, 0));
        tick();

        // illegal opcode 7
        b8.IR = 9'b111_000_000; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick(); chk("ill7", o8(), pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1));
        tick(); chk("ill7_after", o8(), Z);

        // Run held high: one IDLE cycle between back-to-back instructions
        b8.IR = 9'b000_001_010; b8.Run = 1'b1;
        tick(); chk("b2b_t0a", o8(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        tick(); chk("b2b_t1a", o8(), pk(0, 16'h02, 16'h04, 0, 0, 0, 0, 2'b00, 1, 0));
        tick(); chk("b2b_idle", o8(), Z);
        tick(); chk("b2b_t0b", o8(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b8.Run = 1'b0;
        tick(); chk("b2b_t1b", o8(), pk(0, 16'h02, 16'h04, 0, 0, 0, 0, 2'b00, 1, 0));
        tick();

        // add R3,R4 aborted by reset in T2
        b8.IR = 9'b010_011_100; b8.Run = 1'b1;
        tick(); b8.Run = 1'b0;
        tick();
        tick(); chk("add_t2", o8(), pk(0, 0, 16'h10, 0, 1, 0, 0, 2'b00, 0, 0));
        Resetn = 1'b0;
        #1 chk("rst_async", o8(), Z);
        tick(); chk("rst_hold", o8(), Z);
        Resetn = 1'b1;
        tick(); chk("rst_idle", o8(), Z);
        b8.Run = 1'b1;
        tick(); chk("restart_t0", o8(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b8.Run = 1'b0;
        tick(); chk("restart_t1", o8(), pk(0, 0, 16'h08, 1, 0, 0, 0, 2'b00, 0, 0));
        tick();
        tick(); chk("restart_t3", o8(), pk(0, 16'h08, 0, 0, 0, 1, 0, 2'b00, 1, 0));
        tick();

        // 16 registers, 4-bit opcode: opcode 9 illegal, mv R15<-R0
        b16.IR = 12'b1001_0000_0000; b16.Run = 1'b1;
        tick(); chk("w16_t0", o16(), pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        b16.Run = 1'b0;
        tick(); chk("w16_ill9", o16(), pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1));
        tick(); chk("w16_after", o16(), Z);
        b16.IR = 12'b0000_1111_0000; b16.Run = 1'b1;
        tick(); b16.Run = 1'b0;
        tick(); chk("w16_mv", o16(), pk(0, 16'h8000, 16'h0001, 0, 0, 0, 0, 2'b00, 1, 0));
        tick();

        chk("done_count", 64'(n_done), 64'd11);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/cu_param.md
Name: cu_param

Overview:
- Parametrised control unit for the bus-based multi-cycle processor; successor to the fixed 8-register, 4-opcode control unit.
- Sequences one instruction, taken from the external IR register, over 1-3 execute cycles.
- Drives register-file enables, A/G register enables, bus-source selects and an ALU operation code; pulses Done at completion.
- Adds logic ops, a conditional move, illegal-opcode reporting and a proper Run/Done handshake.

Parameters:
NREGS, 8, number of general registers; power of two, >= 2; REGW = clog2(NREGS) (localparam)
OPW, 3, opcode field width; IR_W = OPW + 2*REGW (localparam, 9 at defaults)

Ports:
clk  in  1  clock
Resetn  in  1  reset, asynchronous, active-low
Run  in  1  start request, level, sampled only in IDLE
IR  in  IR_W  instruction {op, x, y}: op = IR[IR_W-1 -: OPW], x = next REGW bits, y = low REGW bits; valid from the cycle after IRin
Gz  in  1  G register == 0 (from datapath)
IRin  out  1  load IR from DIN
Rin  out  NREGS  one-hot register write enable
Rout  out  NREGS  one-hot register bus-drive select
Ain  out  1  load A
Gin  out  1  load G with ALU result
Gout  out  1  G drives bus
DINout  out  1  DIN drives bus
AluOp  out  2  00 add, 01 sub, 10 and, 11 or
Done  out  1  one-cycle completion pulse
Illegal  out  1  one-cycle pulse, coincident with Done, for an undefined opcode

Behaviour:
- Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 and, 5 or, 6 mvnz; 7 and all higher values (OPW > 3) are illegal.
- States: IDLE, T0, T1, T2, T3.
- Outputs are combinational from the state register and IR (Moore plus IR decode).
- Every output not listed for a state is 0. All outputs are 0 in IDLE.
- Reset (asynchronous): state = IDLE; all outputs 0 immediately. Reset mid-instruction aborts it with no Done.
- IDLE: Run = 1 -> T0; otherwise stay.
- T0: IRin = 1 -> T1. IR is latched externally at the end of T0.
- T1 decode:
  - mv: Rout[y], Rin[x], Done -> IDLE.
  - mvi: DINout, Rin[x], Done -> IDLE.
  - mvnz with Gz = 0: same as mv. With Gz = 1: Done only, no Rin or Rout -> IDLE.
  - add/sub/and/or: Rout[x], Ain -> T2.
  - illegal: Done, Illegal, no enables -> IDLE.
- T2: Rout[y], Gin, AluOp = op - 2 -> T3.
- T3: Gout, Rin[x], Done -> IDLE.
- AluOp is held at op - 2 during T2 and T3 for ALU ops and is 00 otherwise.
- Latency from Run sampled to Done:
  - mv/mvi/mvnz/illegal: Done in the 3rd cycle.
  - ALU ops: Done in the 5th cycle.
- Run is ignored outside IDLE. If Run is still high after Done, the next instruction starts in the following IDLE cycle, so IDLE always lasts at least 1 cycle between instructions.
- x == y is legal:
  - mv: drive and load the same register.
  - ALU ops: A = G input = Rx.
- Invariants, checked by assertions:
  - Rin and Rout are one-hot or zero.
  - At most one bus source (any Rout bit, DINout, Gout) is active per cycle.
  - Done and IRin are never high together.
  - Done is high for exactly one cycle per instruction.
- IR must be held stable by the datapath from T1 to Done. The block does not latch IR.

Decomposition:
- Package cu_pkg:
  - opcode localparams OP_MV..OP_MVNZ;
  - state enum/encoding (IDLE=0, T0=1, T1=2, T2=3, T3=4, 3 bits);
  - AluOp codes ALU_ADD/SUB/AND/OR.
- One sub-module: cu_onehot_dec #(N) (index of width clog2(N) -> N-bit one-hot, enable input forces 0). It is instantiated twice, for x and y.

Test Plan:
- Reset asserted mid-T2 of an add -> all outputs 0 within the same cycle; state IDLE; no Done; after release, Run = 1 restarts cleanly at T0.
- mv R3<-R5 (IR = 0_011_101) with Run pulsed -> cycle 2 IRin = 1; cycle 3 Rout = 0x20, Rin = 0x08, Done = 1; cycle 4 all outputs 0.
- sub R1,R2 (IR = 011_001_010) -> T1: Rout = 0x02, Ain = 1; T2: Rout = 0x04, Gin = 1, AluOp = 01; T3: Gout = 1, Rin = 0x02, Done = 1, AluOp = 01.
- mvnz R0<-R7 with Gz = 1 -> Done in T1 with Rin = Rout = 0. Repeat with Gz = 0 -> Rout = 0x80, Rin = 0x01.
- Opcode 7, and with NREGS = 16, OPW = 4 opcode 9 -> Done = Illegal = 1 for one cycle, no enables. Run held high continuously -> back-to-back instructions separated by exactly one IDLE cycle.
- Random instruction stream, 10k cycles, NREGS in {2, 8, 16} -> bus-exclusivity and one-hot assertions never fire; Done count equals the count of accepted Run requests.
